// File: rtl/risc_regstack.sv
// rtl/risc_regstack.sv - register file with hardware LIFO for risc8/risc8x; define RISC_REGSTACK_BYPASS_EN for write-through forwarding
module risc_regstack #(
  parameter int WORD  = 8,
  parameter int REGS  = 4,
  parameter int DEPTH = 16,
  localparam int RA_W = $clog2(REGS),
  localparam int SP_W = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RA_W-1:0] a1,
  input  logic [RA_W-1:0] a2,
  output logic [WORD-1:0] rd1,
  output logic [WORD-1:0] rd2,
  input  logic [RA_W-1:0] a3,
  input  logic [WORD-1:0] wd,
  input  logic            rw_en,
  input  logic [1:0]      stackop,
  input  logic [WORD-1:0] st_wd,
  output logic [WORD-1:0] st_top,
  output logic [SP_W-1:0] sp,
  output logic            st_empty,
  output logic            st_full,
  output logic            st_ovf,
  output logic            st_unf,
  input  logic            st_clr
);

  localparam int IX_W = $clog2(DEPTH);
  localparam logic [1:0] ST_SKIP = 2'b00;
  localparam logic [1:0] ST_ADD  = 2'b01;
  localparam logic [1:0] ST_SUB  = 2'b10;
  localparam logic [1:0] ST_3    = 2'b11;

  logic [WORD-1:0] regs [REGS];
  logic [WORD-1:0] mem  [DEPTH];

  logic [IX_W-1:0] push_ix;
  logic [IX_W-1:0] top_ix;
  logic            do_push;
  logic            do_pop;
  logic            do_rep;
  logic            ovf_ev;
  logic            unf_ev;

  // When full, sp's low bits wrap to 0, so top_ix still lands on DEPTH-1.
  assign push_ix  = sp[IX_W-1:0];
  assign top_ix   = push_ix - IX_W'(1);
  assign st_empty = (sp == '0);
  assign st_full  = (sp == SP_W'(DEPTH));

  assign do_push = (stackop == ST_ADD) && !st_full;
  assign do_pop  = (stackop == ST_SUB) && !st_empty;
  assign do_rep  = (stackop == ST_3)   && !st_empty;
  assign ovf_ev  = (stackop == ST_ADD) && st_full;
  assign unf_ev  = ((stackop == ST_SUB) || (stackop == ST_3)) && st_empty;

`ifdef RISC_REGSTACK_BYPASS_EN
  assign rd1    = (rw_en && (a1 == a3)) ? wd : regs[a1];
  assign rd2    = (rw_en && (a2 == a3)) ? wd : regs[a2];
  assign st_top = (do_push || do_rep) ? st_wd :
                  (st_empty ? {WORD{1'b0}} : mem[top_ix]);
`else
  assign rd1    = regs[a1];
  assign rd2    = regs[a2];
  assign st_top = st_empty ? {WORD{1'b0}} : mem[top_ix];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REGS; i++) regs[i] <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      sp     <= '0;
      st_ovf <= 1'b0;
      st_unf <= 1'b0;
    end else begin
      if (rw_en) regs[a3] <= wd;
      if (do_push) begin
        mem[push_ix] <= st_wd;
        sp           <= sp + SP_W'(1);
      end else if (do_pop) begin
        sp <= sp - SP_W'(1);
      end else if (do_rep) begin
        mem[top_ix] <= st_wd;
      end
      // A fresh error event outranks a simultaneous clear.
      st_ovf <= (st_clr ? 1'b0 : st_ovf) | ovf_ev;
      st_unf <= (st_clr ? 1'b0 : st_unf) | unf_ev;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!$isunknown(stackop));
  end

endmodule
